// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command transmitter.
// FRAME_BITS follows UART_CMD_TX_PARITY_EN (11 with even parity, 10 without).
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } state_e;

  localparam logic [7:0] RF_WR_CMD   = 8'hAA;
  localparam logic [7:0] RF_RD_CMD   = 8'hBB;
  localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
  localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

  localparam logic [1:0] RF_WR_ARGS   = 2'd2;
  localparam logic [1:0] RF_RD_ARGS   = 2'd1;
  localparam logic [1:0] ALU_OP_ARGS  = 2'd3;
  localparam logic [1:0] ALU_NOP_ARGS = 2'd1;

`ifdef UART_CMD_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  function automatic logic [1:0] expected_args(input logic [7:0] op);
    logic [1:0] n;
    case (op)
      RF_WR_CMD:   n = RF_WR_ARGS;
      RF_RD_CMD:   n = RF_RD_ARGS;
      ALU_OP_CMD:  n = ALU_OP_ARGS;
      ALU_NOP_CMD: n = ALU_NOP_ARGS;
      default:     n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_byte_ser.sv
// Serializes one byte as start / data LSB-first / [even parity] / stop, PRESCALE clocks per bit.
// Parity bit present only when UART_CMD_TX_PARITY_EN is defined.
module uart_byte_ser
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  tx_o,
  output logic                  done_o,
  output logic                  cmd_done_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(PRESCALE - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

`ifdef UART_CMD_TX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] b);
    return ^b;
  endfunction

  logic par_q;
`endif

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  tx_q;
  logic                  done_q;
  logic                  cmd_done_q;
  logic                  last_q;
  logic                  cnt_end_s;

  assign cnt_end_s  = (cnt_q == CNT_LAST);
  assign tx_o       = tx_q;
  assign done_o     = done_q;
  assign cmd_done_o = cmd_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      cmd_done_q <= 1'b0;
      last_q     <= 1'b0;
`ifdef UART_CMD_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      cmd_done_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= cnt_end_s ? '0 : cnt_q + CW'(1);
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= START;
            tx_q    <= 1'b0;
            shift_q <= data_i;
            last_q  <= last_i;
`ifdef UART_CMD_TX_PARITY_EN
            par_q   <= even_parity(data_i);
`endif
          end else begin
            tx_q <= 1'b1;
          end
        end
        START: begin
          if (cnt_end_s) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        DATA: begin
          if (cnt_end_s) begin
            if (bit_q == BIT_LAST) begin
`ifdef UART_CMD_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + BW'(1);
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef UART_CMD_TX_PARITY_EN
        PARITY: begin
          if (cnt_end_s) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          // Flag the last clock of the stop bit so the sequencer can chain the next frame.
          if (cnt_q == CNT_PRE) begin
            done_q     <= 1'b1;
            cmd_done_q <= last_q;
          end
          if (cnt_end_s) begin
            if (start_i) begin
              state_q <= START;
              tx_q    <= 1'b0;
              shift_q <= data_i;
              last_q  <= last_i;
`ifdef UART_CMD_TX_PARITY_EN
              par_q   <= even_parity(data_i);
`endif
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// UART command transmitter: latches opcode + CMD_LEN args on handshake and sends them as frames.
// Define UART_CMD_TX_PARITY_EN to add an even parity bit to every frame.
module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 32,
  parameter int GAP_BITS   = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [DATA_WIDTH-1:0] CMD_OP,
  input  logic [DATA_WIDTH-1:0] CMD_ARG0,
  input  logic [DATA_WIDTH-1:0] CMD_ARG1,
  input  logic [DATA_WIDTH-1:0] CMD_ARG2,
  input  logic [1:0]            CMD_LEN,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  CMD_DONE
);

  localparam bit NO_GAP   = (GAP_BITS == 0);
  localparam int GAP_CLKS = (GAP_BITS > 0) ? GAP_BITS * PRESCALE : 1;
  localparam int GAP_CW   = $clog2(GAP_CLKS + 1);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(GAP_CLKS - 1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] op_q, arg0_q, arg1_q, arg2_q;
  logic [1:0]            len_q;
  logic [1:0]            byte_idx_q;
  logic [GAP_CW-1:0]     gap_cnt_q;
  logic                  start_q;
  logic                  ready_q;
  logic                  busy_q;

  logic [1:0]            sel_s;
  logic [DATA_WIDTH-1:0] byte_s;
  logic                  more_s;
  logic                  gap_end_s;
  logic                  ser_start_s;
  logic                  ser_done_s;

  // byte_idx_q is the frame in flight; the byte to load next is idx+1 except for the opcode.
  always_comb begin
    sel_s       = start_q ? 2'd0 : byte_idx_q + 2'd1;
    byte_s      = op_q;
    case (sel_s)
      2'd0:    byte_s = op_q;
      2'd1:    byte_s = arg0_q;
      2'd2:    byte_s = arg1_q;
      2'd3:    byte_s = arg2_q;
      default: byte_s = op_q;
    endcase
    more_s      = (byte_idx_q != len_q);
    gap_end_s   = (gap_cnt_q == GAP_LAST);
    ser_start_s = start_q
                | ((state_q == START) && ser_done_s && more_s && NO_GAP)
                | ((state_q == GAP) && gap_end_s);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      op_q       <= '0;
      arg0_q     <= '0;
      arg1_q     <= '0;
      arg2_q     <= '0;
      len_q      <= 2'd0;
      byte_idx_q <= 2'd0;
      gap_cnt_q  <= '0;
      start_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (CMD_VALID && ready_q) begin
            op_q       <= CMD_OP;
            arg0_q     <= CMD_ARG0;
            arg1_q     <= CMD_ARG1;
            arg2_q     <= CMD_ARG2;
            len_q      <= CMD_LEN;
            byte_idx_q <= 2'd0;
            start_q    <= 1'b1;
            state_q    <= START;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        START: begin
          if (ser_done_s) begin
            if (!more_s) begin
              state_q    <= IDLE;
              byte_idx_q <= 2'd0;
              ready_q    <= 1'b1;
              busy_q     <= 1'b0;
            end else if (NO_GAP) begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end else begin
              state_q   <= GAP;
              gap_cnt_q <= '0;
            end
          end
        end
        GAP: begin
          if (gap_end_s) begin
            gap_cnt_q  <= '0;
            byte_idx_q <= byte_idx_q + 2'd1;
            state_q    <= START;
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  uart_byte_ser #(
    .DATA_WIDTH(DATA_WIDTH),
    .PRESCALE  (PRESCALE)
  ) u_ser (
    .clk_i     (CLK),
    .rst_i     (RST),
    .start_i   (ser_start_s),
    .data_i    (byte_s),
    .last_i    (sel_s == len_q),
    .tx_o      (TX_OUT),
    .done_o    (ser_done_s),
    .cmd_done_o(CMD_DONE)
  );

  assign CMD_READY = ready_q;
  assign BUSY      = busy_q;

endmodule

// File: doc/uart_cmd_tx.md
# uart_cmd_tx

Host-side UART command transmitter: takes one complete command (opcode plus 0–3 argument bytes) over a valid/ready handshake and serializes it on a single TX line. Each byte is sent as a frame: start bit, 8 data bits LSB first, optional even parity, stop bit. Each bit lasts PRESCALE clocks. The block is the sending end of the system's UART command interface. It drives the RX_IN of TOP in system-level benches and in host-bridge builds.

## Interface
Parameters:
- DATA_WIDTH, 8, frame payload width.
- PRESCALE, 32, clocks per bit; ≥ 2.
- GAP_BITS, 0, idle-high bit times between frames of the same command. Not inserted after the last frame.

Ports:
- CLK in 1: single clock; all logic on rising edge.
- RST in 1: reset, synchronous, active-high.
- CMD_VALID in 1: command present.
- CMD_READY out 1: block can accept a command.
- CMD_OP in DATA_WIDTH: opcode byte, always sent first.
- CMD_ARG0 / CMD_ARG1 / CMD_ARG2 in DATA_WIDTH: argument bytes, sent in this order.
- CMD_LEN in 2: number of argument bytes, 0–3.
- TX_OUT out 1: serial line, idle high.
- BUSY out 1: command in flight.
- CMD_DONE out 1: one-cycle pulse when a command completes.

## Operation
- Handshake:
  - Accept on a clock edge where CMD_VALID && CMD_READY.
  - OP, ARG0–2 and LEN are latched at accept; inputs are don't-care afterwards.
  - CMD_READY = 1 only in IDLE, and not during a cycle with RST high.
- The block does not validate opcodes. It sends OP followed by CMD_LEN arguments. Reference commands:
  - AA: 2 args, address then data.
  - BB: 1 arg, address.
  - CC: 3 args, operand A, operand B, function.
  - DD: 1 arg, function.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE → START on accept.
  - START → DATA after PRESCALE clocks.
  - DATA → PARITY after 8 bits; goes straight to STOP when parity is compiled out.
  - PARITY → STOP after PRESCALE clocks.
  - STOP → GAP if more bytes remain and GAP_BITS > 0.
  - STOP → START if more bytes remain and GAP_BITS = 0.
  - STOP → IDLE after the last byte.
  - GAP → START after GAP_BITS × PRESCALE clocks.
- Counters:
  - Clock counter 0..PRESCALE-1, width $clog2(PRESCALE).
  - Bit index 0..7.
  - Byte index 0..CMD_LEN; wraps to 0 on return to IDLE.
- Parity is even: the XOR of the 8 data bits. Examples: 0x04 → 1, 0xA1 → 1, 0xAA → 0.
- TX_OUT levels per state:
  - Low in START.
  - Data bit in DATA.
  - Parity bit in PARITY.
  - High in STOP, GAP and IDLE.
- BUSY = !IDLE.
- Reset values: TX_OUT=1, CMD_READY=0 during reset and 1 the cycle after, BUSY=0, CMD_DONE=0, state IDLE, all counters 0.
- Reset mid-command:
  - Takes effect at the next edge: TX_OUT high, state IDLE.
  - The command is discarded and no CMD_DONE is issued.

## Timing
- Accept at edge N → TX_OUT goes low (start bit) from edge N+1. TX_OUT is registered and glitch-free.
- Every bit is held for exactly PRESCALE clocks.
- Frame length F = 11 bits with parity, 10 without.
- Command duration = (LEN+1)·F·PRESCALE + LEN·GAP_BITS·PRESCALE clocks, measured from edge N+1 through the end of the last stop bit.
- CMD_DONE is high during the final clock of the last stop bit. BUSY falls and CMD_READY rises at the next edge.
- Back-to-back commands: if CMD_VALID is high when CMD_READY rises, the new command is accepted on that edge. Its start bit follows one clock later, so there is exactly one extra idle clock between commands.
- Frames within one command are contiguous when GAP_BITS=0: a stop bit is immediately followed by the next start bit.

## Configuration
- UART_CMD_TX_PARITY_EN:
  - Defined: even parity bit inserted after data; F=11.
  - Undefined: PARITY state and parity logic absent; F=10; STOP follows DATA directly.

## Structure
- Package uart_cmd_pkg holds:
  - State enum.
  - Opcode constants: RF_WR_CMD=8'hAA, RF_RD_CMD=8'hBB, ALU_OP_CMD=8'hCC, ALU_NOP_CMD=8'hDD.
  - Expected argument counts per opcode.
  - FRAME_BITS derived from the macro.
- One sub-module, uart_byte_ser: serializes a single byte (start, data, parity, stop) with PRESCALE timing and pulses on frame end.
- The top level sequences the bytes, inserts gaps and runs the handshake.

## Test plan
All scenarios use PRESCALE=32 and GAP_BITS=0. Bits are sampled at mid-bit.
- Reset: RST high for 2 cycles → TX_OUT=1, BUSY=0, CMD_DONE=0 throughout; CMD_READY=1 on the first cycle after RST drops.
- Write command, OP=AA, LEN=2, args 04, A1:
  - Frames decode to 0xAA/p0, 0x04/p1, 0xA1/p1.
  - First frame bit sequence is 0,0,1,0,1,0,1,0,1,0,1.
  - CMD_DONE occurs 1056 cycles after the start edge.
- Read command, OP=BB, LEN=1, arg 03 → frames 0xBB/p0, 0x03/p0; CMD_DONE after 704 cycles.
- ALU command, OP=CC, LEN=3, args 0A, 0F, 04 → 4 frames with parities 0, 0, 0, 1. CMD_VALID held high with the next command (OP=DD, LEN=1, arg 02) → CMD_READY stays low until after CMD_DONE; the DD start bit follows one idle clock later; the 0x02 frame has parity 1.
- Reset at cycle 100 of an AA command → TX_OUT=1 on the next cycle, no CMD_DONE, state IDLE. A following BB command then transmits correctly.
- Macro undefined, AA with LEN=2 → 10-bit frames, no parity bit, CMD_DONE after 960 cycles.
